fifo_burst_framer: RTL

Downstream consumer of the team's FWFT synchronous FIFO. Pops words through the FIFO read port and re-emits them as a valid/ready stream with `m_last` framing. A burst closes after MAX_BURST words, or (optionally) when the FIFO stays empty for TIMEOUT cycles. One-word lookahead lets `m_last` ride on the final word of each burst, never on a separate beat.

---
 rtl/fifo_burst_framer_pkg.sv | 22 ++
 rtl/fifo_burst_framer_idle_timer.sv | 33 +++
 rtl/fifo_burst_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_burst_framer_pkg.sv
// Shared constants for fifo_burst_framer: FSM state encoding and a width helper.
// Optional idle timeout is enabled by FIFO_BURST_FRAMER_TIMEOUT_EN.
package fifo_burst_framer_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   // Bits needed to count 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         w = w + 32'sd1;
      end
      if (w < 32'sd1) begin
         w = 32'sd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/fifo_burst_framer_idle_timer.sv
// framer_idle_timer: saturating idle counter used to force a burst close.
// Only present when FIFO_BURST_FRAMER_TIMEOUT_EN is defined.
`ifdef FIFO_BURST_FRAMER_TIMEOUT_EN
module framer_idle_timer #(
   parameter int LIMIT = 15,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         hit
);

   localparam logic [W-1:0] CNT_MAX = W'(LIMIT);
   localparam logic [W-1:0] CNT_ONE = W'(1);

   assign hit = (cnt == CNT_MAX);

   // Count enabled idle cycles, stick at LIMIT until cleared.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= {W{1'b0}};
      end else if (clr) begin
         cnt <= {W{1'b0}};
      end else if (en && !hit) begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule
`endif

// File: rtl/fifo_burst_framer.sv
// fifo_burst_framer: drains an FWFT FIFO into a valid/ready stream with m_last framing.
// Define FIFO_BURST_FRAMER_TIMEOUT_EN to also close a burst after TIMEOUT empty cycles.
module fifo_burst_framer
   import fifo_burst_framer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_ren,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int BW = clog2(MAX_BURST);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic [DATA_WIDTH-1:0] hold_data_r;
   logic                  hold_vld_r;
   logic [BW-1:0]         beat_cnt_r;
   logic                  out_free_s;
   logic                  last_beat_s;
   logic                  timeout_hit_s;
   logic                  release_s;
   logic                  rel_last_s;
   logic                  load_s;

   assign out_free_s  = ~m_valid | m_ready;
   assign last_beat_s = (beat_cnt_r == LAST_BEAT);
   assign release_s   = hold_vld_r & out_free_s & (~fifo_empty | last_beat_s | timeout_hit_s);
   // An empty FIFO means the release came from the count limit or the timeout.
   assign rel_last_s  = last_beat_s | fifo_empty;
   assign load_s      = ~fifo_empty & (~hold_vld_r | release_s);
   assign fifo_ren    = load_s;

`ifdef FIFO_BURST_FRAMER_TIMEOUT_EN
   localparam int IW = clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] TO_NEAR = IW'(TIMEOUT - 1);

   logic [IW-1:0] idle_cnt_s;
   logic          idle_sat_s;
   logic          idle_clr_s;
   logic          idle_en_s;

   // The cycle that enters S_WAIT already counts, so the close lands TIMEOUT edges after the pop.
   assign idle_clr_s = load_s | (release_s & fifo_empty);
   assign idle_en_s  = hold_vld_r & fifo_empty & ~release_s;

   framer_idle_timer #(
      .LIMIT (TIMEOUT),
      .W     (IW)
   ) u_idle_timer (
      .clk  (clk),
      .rstn (rstn),
      .clr  (idle_clr_s),
      .en   (idle_en_s),
      .cnt  (idle_cnt_s),
      .hit  (idle_sat_s)
   );

   assign timeout_hit_s = ((idle_cnt_s == TO_NEAR) & fifo_empty) | idle_sat_s;
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state decode for the hold register occupancy.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_nxt_s = S_HOLD;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_HOLD, S_WAIT: begin
            if (release_s && fifo_empty) begin
               state_nxt_s = S_IDLE;
            end else if (fifo_empty) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_HOLD;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, one-word hold register and beat counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= S_IDLE;
         hold_data_r <= {DATA_WIDTH{1'b0}};
         hold_vld_r  <= 1'b0;
         beat_cnt_r  <= {BW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (load_s) begin
            hold_data_r <= fifo_rdata;
            hold_vld_r  <= 1'b1;
         end else if (release_s) begin
            hold_vld_r  <= 1'b0;
         end
         if (release_s) begin
            beat_cnt_r <= rel_last_s ? {BW{1'b0}} : (beat_cnt_r + BEAT_ONE);
         end
      end
   end

   // Output register; contents stay put while the consumer stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_valid <= 1'b0;
         m_data  <= {DATA_WIDTH{1'b0}};
         m_last  <= 1'b0;
      end else if (release_s) begin
         m_valid <= 1'b1;
         m_data  <= hold_data_r;
         m_last  <= rel_last_s;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule
